// File: rtl/sprite_compositor.sv
// sprite_compositor: overlays one 8x8 monochrome hardware sprite (x1/x2/x4
// scaled) on a pixel stream. Position, colour and control are double-buffered
// (host writes go to staging, staging is copied to active at vsync), while the
// bitmap is written directly. One bitmap row is latched per line at hsync, so
// the per-pixel path only needs a horizontal range test and a bit select.
module sprite_compositor #(
  parameter int V_TOTAL = 525
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       visible,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [5:0] bg_rgb,
  input  logic       cfg_we,
  input  logic [4:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [5:0] rgb_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       collision,
  output logic       frame_irq
);

  localparam logic [9:0] LAST_LINE = 10'(V_TOTAL - 1);

  // Scale code to shift amount: 00 -> x1, 01 -> x2, 10/11 -> x4.
  function automatic logic [1:0] scale_shift(input logic [1:0] scl);
    return (scl == 2'b00) ? 2'd0 : (scl == 2'b01) ? 2'd1 : 2'd2;
  endfunction

  // Sprite edge length in pixels for a given shift (8, 16 or 32).
  function automatic logic [9:0] footprint(input logic [1:0] sh);
    return 10'd8 << sh;
  endfunction

  // Range test with an extra borrow bit, so a position "before" the origin
  // never aliases into the sprite by 10-bit wrap-around.
  function automatic logic span_hit(input logic [9:0] pos,
                                    input logic [9:0] org,
                                    input logic [1:0] sh);
    logic [10:0] diff;
    diff = {1'b0, pos} - {1'b0, org};
    return !diff[10] && (diff[9:0] < footprint(sh));
  endfunction

  // Staging (host-visible) and active (display) sprite attributes
  logic [9:0]      stg_x_q, stg_x_d, stg_y_q, stg_y_d;
  logic [5:0]      stg_col_q, stg_col_d;
  logic            stg_en_q, stg_en_d;
  logic [1:0]      stg_scl_q, stg_scl_d;
  logic [9:0]      act_x_q, act_x_d, act_y_q, act_y_d;
  logic [5:0]      act_col_q, act_col_d;
  logic            act_en_q, act_en_d;
  logic [1:0]      act_scl_q, act_scl_d;
  logic [7:0][7:0] bitmap_q, bitmap_d;

  // Per-line latched row
  logic [7:0]      row_q, row_d;
  logic            row_hit_q, row_hit_d;

  // Output stage
  logic [5:0]      rgb_q, rgb_d;
  logic            hsync_out_q, hsync_out_d;
  logic            vsync_out_q, vsync_out_d;
  logic            collision_q, collision_d;
  logic            frame_irq_q, frame_irq_d;

  // Combinational helpers
  logic            vs_rise, hs_rise, coll_clr, opaque;
  logic [1:0]      act_sh;
  logic [9:0]      next_y, dy, dx;
  logic [2:0]      row_idx, bit_idx;

  // The delayed sync outputs double as the registered copies for edge detect.
  assign vs_rise  = vsync_in & ~vsync_out_q;
  assign hs_rise  = hsync_in & ~hsync_out_q;
  assign coll_clr = cfg_we && (cfg_addr == 5'd6) && cfg_wdata[0];
  assign act_sh   = scale_shift(act_scl_q);

  assign next_y   = (pix_y == LAST_LINE) ? 10'd0 : pix_y + 10'd1;
  assign dy       = next_y - act_y_q;
  assign row_idx  = 3'(dy >> act_sh);

  assign dx       = pix_x - act_x_q;
  assign bit_idx  = 3'd7 - 3'(dx >> act_sh);
  assign opaque   = act_en_q && row_hit_q && visible &&
                    span_hit(pix_x, act_x_q, act_sh) && row_q[bit_idx];

  // Host writes into staging/bitmap; staging-to-active copy on vsync rise.
  // Both read the pre-edge staging value, so a write landing on the copy
  // cycle only reaches active at the following frame.
  always_comb begin
    stg_x_d   = stg_x_q;
    stg_y_d   = stg_y_q;
    stg_col_d = stg_col_q;
    stg_en_d  = stg_en_q;
    stg_scl_d = stg_scl_q;
    act_x_d   = act_x_q;
    act_y_d   = act_y_q;
    act_col_d = act_col_q;
    act_en_d  = act_en_q;
    act_scl_d = act_scl_q;
    bitmap_d  = bitmap_q;
    if (vs_rise) begin
      act_x_d   = stg_x_q;
      act_y_d   = stg_y_q;
      act_col_d = stg_col_q;
      act_en_d  = stg_en_q;
      act_scl_d = stg_scl_q;
    end
    if (cfg_we) begin
      case (cfg_addr)
        5'd0: stg_x_d[7:0] = cfg_wdata;
        5'd1: stg_x_d[9:8] = cfg_wdata[1:0];
        5'd2: stg_y_d[7:0] = cfg_wdata;
        5'd3: stg_y_d[9:8] = cfg_wdata[1:0];
        5'd4: stg_col_d    = cfg_wdata[5:0];
        5'd5: begin
          stg_en_d  = cfg_wdata[0];
          stg_scl_d = cfg_wdata[2:1];
        end
        5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15:
          bitmap_d[cfg_addr[2:0]] = cfg_wdata;
        default: ;
      endcase
    end
  end

  // At each line start, fetch the bitmap row for the upcoming line.
  always_comb begin
    row_d     = row_q;
    row_hit_d = row_hit_q;
    if (hs_rise) begin
      row_hit_d = span_hit(next_y, act_y_q, act_sh);
      row_d     = bitmap_q[row_idx];
    end
  end

  // Pixel mux, sync delay, sticky collision (set beats clear) and frame pulse.
  always_comb begin
    if (opaque)       rgb_d = act_col_q;
    else if (visible) rgb_d = bg_rgb;
    else              rgb_d = 6'd0;
    hsync_out_d = hsync_in;
    vsync_out_d = vsync_in;
    frame_irq_d = vs_rise;
    collision_d = collision_q;
    if (coll_clr) collision_d = 1'b0;
    if (opaque && (bg_rgb != 6'd0)) collision_d = 1'b1;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_x_q     <= '0;
      stg_y_q     <= '0;
      stg_col_q   <= '0;
      stg_en_q    <= 1'b0;
      stg_scl_q   <= '0;
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_col_q   <= '0;
      act_en_q    <= 1'b0;
      act_scl_q   <= '0;
      bitmap_q    <= '0;
      row_q       <= '0;
      row_hit_q   <= 1'b0;
      rgb_q       <= '0;
      hsync_out_q <= 1'b0;
      vsync_out_q <= 1'b0;
      collision_q <= 1'b0;
      frame_irq_q <= 1'b0;
    end else begin
      stg_x_q     <= stg_x_d;
      stg_y_q     <= stg_y_d;
      stg_col_q   <= stg_col_d;
      stg_en_q    <= stg_en_d;
      stg_scl_q   <= stg_scl_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      act_col_q   <= act_col_d;
      act_en_q    <= act_en_d;
      act_scl_q   <= act_scl_d;
      bitmap_q    <= bitmap_d;
      row_q       <= row_d;
      row_hit_q   <= row_hit_d;
      rgb_q       <= rgb_d;
      hsync_out_q <= hsync_out_d;
      vsync_out_q <= vsync_out_d;
      collision_q <= collision_d;
      frame_irq_q <= frame_irq_d;
    end
  end

  assign rgb_out   = rgb_q;
  assign hsync_out = hsync_out_q;
  assign vsync_out = vsync_out_q;
  assign collision = collision_q;
  assign frame_irq = frame_irq_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: a table of pixel vectors, hand-written
// sequences for the frame/line timing corners, and a randomized phase, all
// checked against a frame-level reference model held in integers.
module tb_sprite_compositor;

  localparam int VT = 525;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic       visible, hsync_in, vsync_in;
  logic [5:0] bg_rgb;
  logic       cfg_we;
  logic [4:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [5:0] rgb_out;
  logic       hsync_out, vsync_out, collision, frame_irq;

  always #5 clk = ~clk;

  sprite_compositor #(.V_TOTAL(VT)) dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .visible(visible), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .bg_rgb(bg_rgb), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .rgb_out(rgb_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .collision(collision), .frame_irq(frame_irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sprite attributes as plain integers
  int m_sx, m_sy, m_scol, m_sen, m_sscl;
  int m_ax, m_ay, m_acol, m_aen, m_ascl;
  int m_bmp[8];
  int m_row;
  bit m_row_ok, m_hs_prev, m_vs_prev;
  int e_rgb;
  bit e_hs, e_vs, e_irq, e_col;

  function automatic int mag(input int scl);
    return (scl == 0) ? 1 : (scl == 1) ? 2 : 4;
  endfunction

  task automatic model_edge();
    int sc, fp, x, y, ny;
    bit opq;
    if (!rst_n) begin
      m_sx = 0; m_sy = 0; m_scol = 0; m_sen = 0; m_sscl = 0;
      m_ax = 0; m_ay = 0; m_acol = 0; m_aen = 0; m_ascl = 0;
      for (int i = 0; i < 8; i++) m_bmp[i] = 0;
      m_row = 0; m_row_ok = 0; m_hs_prev = 0; m_vs_prev = 0;
      e_rgb = 0; e_hs = 0; e_vs = 0; e_irq = 0; e_col = 0;
      return;
    end
    sc = mag(m_ascl);
    fp = 8 * sc;
    x  = int'(pix_x);
    y  = int'(pix_y);
    opq = 1'b0;
    if (m_aen != 0 && m_row_ok && visible && x >= m_ax && x < m_ax + fp)
      opq = ((m_row >> (7 - (x - m_ax) / sc)) & 1) != 0;
    e_rgb = opq ? m_acol : (visible ? int'(bg_rgb) : 0);
    e_hs  = hsync_in;
    e_vs  = vsync_in;
    e_irq = vsync_in && !m_vs_prev;
    if (cfg_we && cfg_addr == 5'd6 && cfg_wdata[0]) e_col = 1'b0;
    if (opq && bg_rgb != 6'd0) e_col = 1'b1;
    if (hsync_in && !m_hs_prev) begin
      ny = (y == VT - 1) ? 0 : y + 1;
      m_row_ok = (ny >= m_ay) && (ny < m_ay + fp);
      if (m_row_ok) m_row = m_bmp[(ny - m_ay) / sc];
    end
    if (vsync_in && !m_vs_prev) begin
      m_ax = m_sx; m_ay = m_sy; m_acol = m_scol; m_aen = m_sen; m_ascl = m_sscl;
    end
    if (cfg_we) begin
      case (cfg_addr)
        5'd0: m_sx = (m_sx & 'h300) | int'(cfg_wdata);
        5'd1: m_sx = (m_sx & 'h0FF) | (int'(cfg_wdata[1:0]) << 8);
        5'd2: m_sy = (m_sy & 'h300) | int'(cfg_wdata);
        5'd3: m_sy = (m_sy & 'h0FF) | (int'(cfg_wdata[1:0]) << 8);
        5'd4: m_scol = int'(cfg_wdata[5:0]);
        5'd5: begin m_sen = int'(cfg_wdata[0]); m_sscl = int'(cfg_wdata[2:1]); end
        5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15:
          m_bmp[int'(cfg_addr[2:0])] = int'(cfg_wdata);
        default: ;
      endcase
    end
    m_hs_prev = hsync_in;
    m_vs_prev = vsync_in;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs sampled at the edge, then
  // compare every output shortly after the edge.
  task automatic tick();
    logic [9:0] got, exp;
    @(posedge clk);
    model_edge();
    #1;
    got = {rgb_out, hsync_out, vsync_out, frame_irq, collision};
    exp = {6'(e_rgb), e_hs, e_vs, e_irq, e_col};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL stream: rgb/hs/vs/irq/col got %b expected %b (t=%0t)", got, exp, $time);
    end
  endtask

  task automatic cfg(input logic [4:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    tick();
    chk("frame_irq_high", 32'(frame_irq), 32'h1);
    tick();
    chk("frame_irq_low", 32'(frame_irq), 32'h0);
    vsync_in = 1'b0;
    tick();
  endtask

  task automatic latch(input logic [9:0] y);
    visible = 1'b0; pix_y = y; hsync_in = 1'b1;
    tick();
    hsync_in = 1'b0;
    tick();
  endtask

  task automatic pix(input string nm, input logic [9:0] x, input logic [5:0] bg,
                     input logic [5:0] exp);
    pix_x = x; visible = 1'b1; bg_rgb = bg;
    tick();
    chk(nm, 32'(rgb_out), 32'(exp));
  endtask

  task automatic coll_pix(input string nm, input logic [7:0] clr, input logic [9:0] x,
                          input logic [5:0] bg, input logic exp);
    cfg_we = 1'b1; cfg_addr = 5'd6; cfg_wdata = clr;
    pix_x = x; visible = 1'b1; bg_rgb = bg;
    tick();
    cfg_we = 1'b0;
    chk(nm, 32'(collision), 32'(exp));
  endtask

  typedef struct {
    logic [9:0] x;
    logic       vis;
    logic [5:0] bg;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Line 50 of a sprite at X=100, row0=0x81, colour 0x3F, scale x1
    tbl[0] = '{10'd99,  1'b1, 6'h05, 6'h05};
    tbl[1] = '{10'd100, 1'b1, 6'h05, 6'h3F};
    tbl[2] = '{10'd101, 1'b1, 6'h05, 6'h05};
    tbl[3] = '{10'd106, 1'b1, 6'h05, 6'h05};
    tbl[4] = '{10'd107, 1'b1, 6'h05, 6'h3F};
    tbl[5] = '{10'd108, 1'b1, 6'h05, 6'h05};
    tbl[6] = '{10'd100, 1'b0, 6'h05, 6'h00};
    tbl[7] = '{10'd107, 1'b1, 6'h00, 6'h3F};
    tbl[8] = '{10'd101, 1'b1, 6'h2A, 6'h2A};

    rst_n = 1'b0; pix_x = '0; pix_y = '0; visible = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; bg_rgb = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    tick();
    tick();
    chk("reset_outputs", 32'({rgb_out, hsync_out, vsync_out, frame_irq, collision}), 32'h0);
    rst_n = 1'b1;

    // Basic sprite, table-driven pixels on line 50
    cfg(5'd0, 8'd100); cfg(5'd1, 8'd0); cfg(5'd2, 8'd50); cfg(5'd3, 8'd0);
    cfg(5'd4, 8'h3F);  cfg(5'd5, 8'h01); cfg(5'd8, 8'h81);
    vsync_pulse();
    latch(10'd49);
    for (int i = 0; i < 9; i++) begin
      pix_x = tbl[i].x; visible = tbl[i].vis; bg_rgb = tbl[i].bg;
      tick();
      chk($sformatf("tbl%0d", i), 32'(rgb_out), 32'(tbl[i].exp));
    end

    // Scale x2: pixels 10,11 on lines 50 and 51
    cfg(5'd0, 8'd10); cfg(5'd5, 8'h03); cfg(5'd8, 8'h80);
    vsync_pulse();
    latch(10'd49);
    pix("x2_l0_p10", 10'd10, 6'h05, 6'h3F);
    pix("x2_l0_p11", 10'd11, 6'h05, 6'h3F);
    pix("x2_l0_p12", 10'd12, 6'h05, 6'h05);
    pix("x2_l0_p9",  10'd9,  6'h05, 6'h05);
    latch(10'd50);
    pix("x2_l1_p10", 10'd10, 6'h05, 6'h3F);
    pix("x2_l1_p11", 10'd11, 6'h05, 6'h3F);
    pix("x2_l1_p12", 10'd12, 6'h05, 6'h05);
    latch(10'd51);
    pix("x2_l2_p10", 10'd10, 6'h05, 6'h05);

    // X write coinciding with the vsync copy
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 8'd200; vsync_in = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk("race_irq_high", 32'(frame_irq), 32'h1);
    tick();
    chk("race_irq_low", 32'(frame_irq), 32'h0);
    vsync_in = 1'b0;
    tick();
    latch(10'd49);
    pix("race_old_x10",  10'd10,  6'h05, 6'h3F);
    pix("race_old_x200", 10'd200, 6'h05, 6'h05);
    vsync_pulse();
    latch(10'd49);
    pix("race_new_x200", 10'd200, 6'h05, 6'h3F);
    pix("race_new_x201", 10'd201, 6'h05, 6'h3F);
    pix("race_new_x10",  10'd10,  6'h05, 6'h05);

    // Y=0 latched at the last line of the frame
    cfg(5'd2, 8'd0); cfg(5'd5, 8'h01); cfg(5'd8, 8'hFF);
    vsync_pulse();
    latch(10'(VT - 1));
    pix("y0_p200", 10'd200, 6'h05, 6'h3F);
    pix("y0_p207", 10'd207, 6'h05, 6'h3F);
    pix("y0_p208", 10'd208, 6'h05, 6'h05);
    pix("y0_p199", 10'd199, 6'h05, 6'h05);
    latch(10'd0);
    pix("y1_p200", 10'd200, 6'h05, 6'h05);

    // No horizontal wrap at X=1020
    cfg(5'd0, 8'hFC); cfg(5'd1, 8'h03);
    vsync_pulse();
    latch(10'(VT - 1));
    pix("hw_p1020", 10'd1020, 6'h05, 6'h3F);
    pix("hw_p1023", 10'd1023, 6'h05, 6'h3F);
    pix("hw_p0",    10'd0,    6'h05, 6'h05);
    pix("hw_p3",    10'd3,    6'h05, 6'h05);

    // No vertical wrap at Y=1020
    cfg(5'd0, 8'h00); cfg(5'd1, 8'h00); cfg(5'd2, 8'hFC); cfg(5'd3, 8'h03);
    vsync_pulse();
    latch(10'd1);
    pix("vw_line2", 10'd0, 6'h05, 6'h05);
    latch(10'd1019);
    pix("vw_line1020", 10'd0, 6'h05, 6'h3F);

    // Collision: set, clear, set-beats-clear
    pix("coll_pre", 10'd0, 6'h01, 6'h3F);
    chk("coll_set0", 32'(collision), 32'h1);
    coll_pix("coll_clear", 8'h01, 10'd500, 6'h01, 1'b0);
    pix("coll_bg0", 10'd0, 6'h00, 6'h3F);
    chk("coll_bg0_noset", 32'(collision), 32'h0);
    pix("coll_bg1", 10'd1, 6'h01, 6'h3F);
    chk("coll_set", 32'(collision), 32'h1);
    coll_pix("coll_set_wins", 8'h01, 10'd2, 6'h01, 1'b1);
    coll_pix("coll_bit0_low", 8'hFE, 10'd500, 6'h01, 1'b1);
    coll_pix("coll_clear2", 8'h01, 10'd500, 6'h01, 1'b0);

    // Enable toggling only masks output; latched row survives
    cfg(5'd5, 8'h00);
    vsync_pulse();
    pix("en_off", 10'd0, 6'h07, 6'h07);
    cfg(5'd5, 8'h01);
    vsync_pulse();
    pix("en_on", 10'd0, 6'h07, 6'h3F);

    // Reset mid-line
    pix_x = 10'd0; visible = 1'b1; bg_rgb = 6'h01; hsync_in = 1'b1; vsync_in = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("midreset_outputs", 32'({rgb_out, hsync_out, vsync_out, frame_irq, collision}), 32'h0);
    rst_n = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; visible = 1'b0;
    tick();
    cfg(5'd0, 8'd0); cfg(5'd1, 8'd0); cfg(5'd2, 8'd0); cfg(5'd3, 8'd0);
    cfg(5'd4, 8'h3F); cfg(5'd5, 8'h01); cfg(5'd8, 8'hFF);
    pix("rst_no_copy", 10'd0, 6'h02, 6'h02);
    vsync_pulse();
    pix("rst_no_latch", 10'd0, 6'h02, 6'h02);
    latch(10'(VT - 1));
    pix("rst_drawn", 10'd0, 6'h02, 6'h3F);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 499) != 0);
      pix_x    = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(1016, 1023))
                                              : 10'($urandom_range(0, 300));
      pix_y    = ($urandom_range(0, 31) == 0) ? 10'(VT - 1) : 10'($urandom_range(0, 300));
      visible  = ($urandom_range(0, 7) != 0);
      bg_rgb   = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0)  hsync_in = ~hsync_in;
      if ($urandom_range(0, 59) == 0) vsync_in = ~vsync_in;
      cfg_we    = ($urandom_range(0, 9) == 0);
      cfg_addr  = 5'($urandom_range(0, 20));
      cfg_wdata = 8'($urandom_range(0, 255));
      if ((cfg_addr == 5'd1 || cfg_addr == 5'd3) && $urandom_range(0, 7) != 0) cfg_wdata = 8'h00;
      if (cfg_addr == 5'd5 && $urandom_range(0, 3) != 0) cfg_wdata[0] = 1'b1;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
